// File: rtl/design_select_ctrl_if.sv
// Wishbone slave bundle for the design-select controller.
// Member names keep the Wishbone slave-side naming used across the top level.
interface design_select_ctrl_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/design_select_ctrl.sv
// Project selector: Wishbone registers plus the isolate/hold/release reset sequencer
// that feeds the pad multiplexer.
module design_select_ctrl #(
  parameter int          NUM_DESIGNS = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [7:0]  HOLD_RESET  = 8'd16
) (
  input  logic                   wb_clk_i,
  input  logic                   rst_n,
  design_select_ctrl_if.slave    wb,
  output logic [NUM_DESIGNS-1:0] design_rst_n,
  output logic [3:0]             active_sel,
  output logic                   isolate,
  output logic [31:0]            custom_settings,
  output logic                   switch_irq
);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLD, RELEASE} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [3:0]             pendSel_q, pendSel_d;
  logic [7:0]             holdLen_q, holdLen_d;
  logic [31:0]            custom_q, custom_d;
  logic                   ack_q, ack_d;
  logic [31:0]            rdData_q, rdData_d;
  logic [NUM_DESIGNS-1:0] designRst_q, designRst_d;
  logic [3:0]             activeSel_q, activeSel_d;
  logic                   isolate_q, isolate_d;
  logic                   irq_q, irq_d;

  logic        accept;
  logic        start;
  logic        busy;
  logic        selValid;
  logic [31:0] readValue;
  logic        unusedAdr;

  assign unusedAdr = ^wb.wbs_adr_i[1:0];
  assign busy      = (state_q != IDLE);
  assign selValid  = (32'(pendSel_q) < 32'(NUM_DESIGNS));
  assign accept    = wb.wbs_cyc_i & wb.wbs_stb_i & ~ack_q &
                     (wb.wbs_adr_i[31:4] == BASE_ADDR[31:4]);

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      pendSel_q   <= 4'hF;
      holdLen_q   <= HOLD_RESET;
      custom_q    <= 32'd0;
      ack_q       <= 1'b0;
      rdData_q    <= 32'd0;
      designRst_q <= '0;
      activeSel_q <= 4'hF;
      isolate_q   <= 1'b1;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pendSel_q   <= pendSel_d;
      holdLen_q   <= holdLen_d;
      custom_q    <= custom_d;
      ack_q       <= ack_d;
      rdData_q    <= rdData_d;
      designRst_q <= designRst_d;
      activeSel_q <= activeSel_d;
      isolate_q   <= isolate_d;
      irq_q       <= irq_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pendSel_d   = pendSel_q;
    holdLen_d   = holdLen_q;
    custom_d    = custom_q;
    ack_d       = 1'b0;
    rdData_d    = rdData_q;
    designRst_d = designRst_q;
    activeSel_d = activeSel_q;
    isolate_d   = isolate_q;
    irq_d       = 1'b0;
    start       = 1'b0;
    readValue   = 32'd0;

    case (wb.wbs_adr_i[3:2])
      2'd0:    readValue = {28'd0, pendSel_q};
      2'd1:    readValue = custom_q;
      2'd2:    readValue = {26'd0, isolate_q, busy, activeSel_q};
      default: readValue = {24'd0, holdLen_q};
    endcase

    if (accept) begin
      ack_d    = 1'b1;
      rdData_d = readValue;
      if (wb.wbs_we_i) begin
        case (wb.wbs_adr_i[3:2])
          2'd0: begin
            if (wb.wbs_sel_i[0]) begin
              pendSel_d = wb.wbs_dat_i[3:0];
              start     = 1'b1;
            end
          end
          2'd1: begin
            for (int b = 0; b < 4; b++) begin
              if (wb.wbs_sel_i[b]) custom_d[8*b +: 8] = wb.wbs_dat_i[8*b +: 8];
            end
          end
          2'd3: begin
            if (wb.wbs_sel_i[0]) holdLen_d = wb.wbs_dat_i[7:0];
          end
          default: ;
        endcase
      end
    end

    // The hold length is latched when HOLD is entered, so later HOLD writes wait for the next sequence.
    case (state_q)
      ASSERT: begin
        state_d = HOLD;
        cnt_d   = (holdLen_q == 8'd0) ? 8'd0 : holdLen_q - 8'd1;
      end
      HOLD: begin
        if (cnt_q == 8'd0) state_d = RELEASE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      RELEASE: begin
        state_d = IDLE;
        irq_d   = 1'b1;
        if (selValid) begin
          designRst_d = NUM_DESIGNS'(1) << pendSel_q;
          activeSel_d = pendSel_q;
          isolate_d   = 1'b0;
        end else begin
          designRst_d = '0;
          activeSel_d = 4'hF;
          isolate_d   = 1'b1;
        end
      end
      default: ;
    endcase

    // A new selection always wins, even mid-sequence or on the release edge.
    if (start) begin
      state_d     = ASSERT;
      designRst_d = '0;
      activeSel_d = 4'hF;
      isolate_d   = 1'b1;
      irq_d       = 1'b0;
    end
  end

  assign wb.wbs_ack_o    = ack_q;
  assign wb.wbs_dat_o    = rdData_q;
  assign design_rst_n    = designRst_q;
  assign active_sel      = activeSel_q;
  assign isolate         = isolate_q;
  assign custom_settings = custom_q;
  assign switch_irq      = irq_q;

endmodule

// File: tb/tb_design_select_ctrl.sv
// Testbench for design_select_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a timeline-based reference model.
module tb_design_select_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          ND   = 12;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  design_select_ctrl_if wbIf();

  logic [ND-1:0] designRstN;
  logic [3:0]    activeSel;
  logic          isolate;
  logic [31:0]   customSettings;
  logic          switchIrq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  design_select_ctrl #(.NUM_DESIGNS(ND), .BASE_ADDR(BASE), .HOLD_RESET(8'd16)) dut (
    .wb_clk_i        (clk),
    .rst_n           (rstN),
    .wb              (wbIf.slave),
    .design_rst_n    (designRstN),
    .active_sel      (activeSel),
    .isolate         (isolate),
    .custom_settings (customSettings),
    .switch_irq      (switchIrq)
  );

  // Reference model: a release is scheduled eff_hold+2 edges after the accepted SEL write.
  logic [3:0]    mSel;
  logic [7:0]    mHold;
  logic [31:0]   mCustom;
  logic          mAck;
  logic [31:0]   mDat;
  logic [ND-1:0] mRst;
  logic [3:0]    mAct;
  logic          mIso;
  logic          mIrq;
  int            mLeft;
  logic          mAccept;
  logic          mStart;
  logic [1:0]    mReg;

  function automatic logic [31:0] readModel(input logic [1:0] r);
    case (r)
      2'd0:    return {28'd0, mSel};
      2'd1:    return mCustom;
      2'd2:    return {26'd0, mIso, (mLeft > 0), mAct};
      default: return {24'd0, mHold};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rstN) begin
      mSel = 4'hF; mHold = 8'd16; mCustom = 32'd0; mAck = 1'b0; mDat = 32'd0;
      mRst = '0; mAct = 4'hF; mIso = 1'b1; mIrq = 1'b0; mLeft = 0;
    end else begin
      mAccept = wbIf.wbs_cyc_i && wbIf.wbs_stb_i && !mAck &&
                (wbIf.wbs_adr_i[31:4] == BASE[31:4]);
      mReg   = wbIf.wbs_adr_i[3:2];
      mStart = 1'b0;
      if (mAccept) mDat = readModel(mReg);
      mAck = mAccept;
      mIrq = 1'b0;
      if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 0) begin
          mIrq = 1'b1;
          if (int'(mSel) < ND) begin
            mRst = ND'(1) << mSel; mAct = mSel; mIso = 1'b0;
          end else begin
            mRst = '0; mAct = 4'hF; mIso = 1'b1;
          end
        end
      end
      if (mAccept && wbIf.wbs_we_i) begin
        if (mReg == 2'd0 && wbIf.wbs_sel_i[0]) begin
          mSel = wbIf.wbs_dat_i[3:0];
          mStart = 1'b1;
        end
        if (mReg == 2'd1)
          for (int b = 0; b < 4; b++)
            if (wbIf.wbs_sel_i[b]) mCustom[8*b +: 8] = wbIf.wbs_dat_i[8*b +: 8];
        if (mReg == 2'd3 && wbIf.wbs_sel_i[0]) mHold = wbIf.wbs_dat_i[7:0];
      end
      if (mStart) begin
        mLeft = (mHold == 8'd0) ? 3 : int'(mHold) + 2;
        mRst = '0; mAct = 4'hF; mIso = 1'b1; mIrq = 1'b0;
      end
    end
  end

  // Bus drivers hold the request until acked (bounded), returning just after the accepting edge.
  task automatic busIdle();
    wbIf.wbs_cyc_i = 1'b0; wbIf.wbs_stb_i = 1'b0; wbIf.wbs_we_i = 1'b0;
    wbIf.wbs_sel_i = 4'h0; wbIf.wbs_adr_i = 32'd0; wbIf.wbs_dat_i = 32'd0;
  endtask

  task automatic wbWrite(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel, output logic acked);
    wbIf.wbs_cyc_i = 1'b1; wbIf.wbs_stb_i = 1'b1; wbIf.wbs_we_i = 1'b1;
    wbIf.wbs_sel_i = sel; wbIf.wbs_adr_i = addr; wbIf.wbs_dat_i = data;
    acked = 1'b0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk); #1;
      acked = wbIf.wbs_ack_o;
    end
    busIdle();
  endtask

  task automatic wbRead(input logic [31:0] addr, output logic [31:0] data, output logic acked);
    wbIf.wbs_cyc_i = 1'b1; wbIf.wbs_stb_i = 1'b1; wbIf.wbs_we_i = 1'b0;
    wbIf.wbs_sel_i = 4'hF; wbIf.wbs_adr_i = addr; wbIf.wbs_dat_i = 32'd0;
    acked = 1'b0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk); #1;
      acked = wbIf.wbs_ack_o;
    end
    data = wbIf.wbs_dat_o;
    busIdle();
  endtask

  task automatic test_reset();
    logic [31:0] d; logic a;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({designRstN, activeSel, isolate, switchIrq} !== {12'h000, 4'hF, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h expected %h",
                         {designRstN, activeSel, isolate, switchIrq}, {12'h000, 4'hF, 1'b1, 1'b0});
    end
    checks++;
    if ({customSettings, wbIf.wbs_ack_o, wbIf.wbs_dat_o} !== {32'd0, 1'b0, 32'd0}) begin
      errors++; $display("[TB] FAIL reset_bus: custom %h ack %b dat %h expected all zero",
                         customSettings, wbIf.wbs_ack_o, wbIf.wbs_dat_o);
    end
    rstN = 1'b1;
    wbRead(BASE + 32'h8, d, a);
    checks++;
    if (!a || d !== 32'h2F) begin errors++; $display("[TB] FAIL reset_status: got %h ack %b expected 0000002f", d, a); end
    wbRead(BASE + 32'h0, d, a);
    checks++;
    if (!a || d !== 32'hF) begin errors++; $display("[TB] FAIL reset_sel: got %h expected 0000000f", d); end
    wbRead(BASE + 32'hC, d, a);
    checks++;
    if (!a || d !== 32'h10) begin errors++; $display("[TB] FAIL reset_hold: got %h expected 00000010", d); end
  endtask

  task automatic test_switch();
    logic [31:0] d; logic a; logic early;
    wbWrite(BASE, 32'd3, 4'b0001, a);
    early = 1'b0;
    repeat (17) begin @(posedge clk); #1; if (designRstN !== 12'h000 || switchIrq) early = 1'b1; end
    checks++;
    if (!a || early) begin errors++; $display("[TB] FAIL switch_early: ack %b early %b expected ack 1 early 0", a, early); end
    @(posedge clk); #1;
    checks++;
    if ({designRstN, activeSel, isolate, switchIrq} !== {12'h008, 4'd3, 1'b0, 1'b1}) begin
      errors++; $display("[TB] FAIL switch_release: got %h expected %h",
                         {designRstN, activeSel, isolate, switchIrq}, {12'h008, 4'd3, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
    checks++;
    if (switchIrq !== 1'b0) begin errors++; $display("[TB] FAIL switch_irq_pulse: got %b expected 0", switchIrq); end
    wbRead(BASE + 32'h8, d, a);
    checks++;
    if (!a || d !== 32'h03) begin errors++; $display("[TB] FAIL switch_status: got %h expected 00000003", d); end
  endtask

  task automatic test_zero_hold();
    logic a; logic early;
    wbWrite(BASE + 32'hC, 32'd0, 4'b0001, a);
    wbWrite(BASE, 32'd11, 4'b0001, a);
    early = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (designRstN !== 12'h000 || !isolate) early = 1'b1; end
    @(posedge clk); #1;
    checks++;
    if (early || designRstN !== 12'h800 || activeSel !== 4'd11 || !switchIrq) begin
      errors++; $display("[TB] FAIL zero_hold: rst %h sel %0d irq %b early %b expected rst 800 sel 11 irq 1 early 0",
                         designRstN, activeSel, switchIrq, early);
    end
    wbWrite(BASE + 32'hC, 32'd16, 4'b0001, a);
  endtask

  task automatic test_restart();
    logic a; logic sawOther; int irqCount;
    irqCount = 0; sawOther = 1'b0;
    wbWrite(BASE, 32'd5, 4'b0001, a);
    repeat (3) begin @(posedge clk); #1; if (switchIrq) irqCount++; end
    wbWrite(BASE, 32'd7, 4'b0001, a);
    repeat (17) begin @(posedge clk); #1; if (switchIrq) irqCount++; if (designRstN !== 12'h000) sawOther = 1'b1; end
    @(posedge clk); #1;
    if (switchIrq) irqCount++;
    checks++;
    if (designRstN !== 12'h080 || sawOther) begin
      errors++; $display("[TB] FAIL restart_release: got %h early %b expected 080 early 0", designRstN, sawOther);
    end
    repeat (5) begin @(posedge clk); #1; if (switchIrq) irqCount++; end
    checks++;
    if (irqCount != 1) begin errors++; $display("[TB] FAIL restart_irq_count: got %0d expected 1", irqCount); end
  endtask

  task automatic test_invalid_sel();
    logic [31:0] d; logic a;
    wbWrite(BASE, 32'd2, 4'b0001, a);
    repeat (18) @(posedge clk);
    #1;
    checks++;
    if (designRstN !== 12'h004) begin errors++; $display("[TB] FAIL invalid_pre: got %h expected 004", designRstN); end
    wbWrite(BASE, 32'd12, 4'b0001, a);
    checks++;
    if ({designRstN, activeSel, isolate} !== {12'h000, 4'hF, 1'b1}) begin
      errors++; $display("[TB] FAIL invalid_assert: got %h expected %h", {designRstN, activeSel, isolate}, {12'h000, 4'hF, 1'b1});
    end
    repeat (18) @(posedge clk);
    #1;
    checks++;
    if ({designRstN, activeSel, isolate, switchIrq} !== {12'h000, 4'hF, 1'b1, 1'b1}) begin
      errors++; $display("[TB] FAIL invalid_release: got %h expected %h",
                         {designRstN, activeSel, isolate, switchIrq}, {12'h000, 4'hF, 1'b1, 1'b1});
    end
    wbRead(BASE + 32'h8, d, a);
    checks++;
    if (d !== 32'h2F) begin errors++; $display("[TB] FAIL invalid_status: got %h expected 0000002f", d); end
  endtask

  task automatic test_custom();
    logic [31:0] d; logic a;
    rstN = 1'b0; repeat (2) @(posedge clk); #1; rstN = 1'b1;
    wbWrite(BASE + 32'h4, 32'hDEADBEEF, 4'b0101, a);
    checks++;
    if (!a || customSettings !== 32'h00AD00EF) begin errors++; $display("[TB] FAIL custom_lanes: got %h expected 00ad00ef", customSettings); end
    wbRead(BASE + 32'h4, d, a);
    checks++;
    if (d !== 32'h00AD00EF) begin errors++; $display("[TB] FAIL custom_readback: got %h expected 00ad00ef", d); end
    wbWrite(BASE + 32'h10, 32'd5, 4'hF, a);
    checks++;
    if (a) begin errors++; $display("[TB] FAIL miss_ack: got ack 1 expected 0"); end
    wbWrite(BASE + 32'h14, 32'hFFFFFFFF, 4'hF, a);
    wbWrite(BASE + 32'h8, 32'h0, 4'hF, a);
    checks++;
    if (!a) begin errors++; $display("[TB] FAIL status_write_ack: got ack 0 expected 1"); end
    wbRead(BASE, d, a);
    checks++;
    if (d !== 32'hF || customSettings !== 32'h00AD00EF || !isolate) begin
      errors++; $display("[TB] FAIL miss_side_effect: sel %h custom %h iso %b expected f 00ad00ef 1", d, customSettings, isolate);
    end
  endtask

  task automatic test_reset_mid_hold();
    logic a; int irqCount; logic anyRelease;
    wbWrite(BASE, 32'd4, 4'b0001, a);
    repeat (5) @(posedge clk);
    #1;
    rstN = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({designRstN, activeSel, isolate, switchIrq, customSettings, wbIf.wbs_ack_o} !==
        {12'h000, 4'hF, 1'b1, 1'b0, 32'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL mid_hold_reset: rst %h sel %h iso %b irq %b custom %h",
                         designRstN, activeSel, isolate, switchIrq, customSettings);
    end
    rstN = 1'b1;
    irqCount = 0; anyRelease = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (switchIrq) irqCount++; if (designRstN !== 12'h000) anyRelease = 1'b1; end
    checks++;
    if (irqCount != 0 || anyRelease) begin
      errors++; $display("[TB] FAIL mid_hold_no_irq: irqs %0d release %b expected 0 0", irqCount, anyRelease);
    end
  endtask

  task automatic test_random();
    int r; int driveEdges; int gap; logic a;
    rstN = 1'b0; @(posedge clk); #1; rstN = 1'b1;
    wbWrite(BASE + 32'hC, 32'd3, 4'b0001, a);
    for (int t = 0; t < 90; t++) begin
      if ($urandom_range(0, 24) == 0) begin
        rstN = 1'b0; @(posedge clk); #1; rstN = 1'b1;
      end
      r = $urandom_range(0, 5);
      wbIf.wbs_adr_i = (r == 5) ? BASE + 32'h100 : BASE + 32'(r * 4);
      wbIf.wbs_we_i  = 1'($urandom_range(0, 1));
      wbIf.wbs_sel_i = 4'($urandom);
      wbIf.wbs_dat_i = $urandom;
      if (r == 0) wbIf.wbs_dat_i = 32'($urandom_range(0, 15));
      if (r == 3) wbIf.wbs_dat_i = 32'($urandom_range(0, 5));
      wbIf.wbs_cyc_i = 1'b1; wbIf.wbs_stb_i = 1'b1;
      driveEdges = $urandom_range(1, 3);
      gap = $urandom_range(0, 14);
      for (int c = 0; c < driveEdges + gap; c++) begin
        @(posedge clk); #1;
        if (c == driveEdges - 1) busIdle();
        checks++;
        if ({designRstN, activeSel, isolate, switchIrq} !== {mRst, mAct, mIso, mIrq}) begin
          errors++; $display("[TB] FAIL rand_outputs t=%0d: got %h expected %h",
                             t, {designRstN, activeSel, isolate, switchIrq}, {mRst, mAct, mIso, mIrq});
        end
        checks++;
        if ({wbIf.wbs_ack_o, wbIf.wbs_dat_o, customSettings} !== {mAck, mDat, mCustom}) begin
          errors++; $display("[TB] FAIL rand_bus t=%0d: got %h expected %h",
                             t, {wbIf.wbs_ack_o, wbIf.wbs_dat_o, customSettings}, {mAck, mDat, mCustom});
        end
        checks++;
        if ($countones(designRstN) > 1) begin
          errors++; $display("[TB] FAIL rand_onehot t=%0d: got %h expected at most one bit", t, designRstN);
        end
      end
    end
  endtask

  initial begin
    busIdle();
    test_reset();
    test_switch();
    test_zero_hold();
    test_restart();
    test_invalid_sel();
    test_custom();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
